// File: rtl/spi_frame_receiver.sv
// Deserialises MSB-first frames from an oversampled two-wire SPI link.
// Optional checksum flag output: define SPI_RX_CHECKSUM_EN.
module spi_frame_receiver #(
  parameter int DATA_W       = 40,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [CNT_W-1:0]  bit_count,
  output logic              frame_err,
  output logic              overrun,
`ifdef SPI_RX_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic              busy
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [1:0]        sclk_sync;
  logic [1:0]        data_sync;
  logic              sclk_dly;
  logic              sample;
  logic              bit_in;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_n;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] data_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  idle_cnt;
  logic [CNT_W-1:0]  idle_n;
  logic              valid_n;
  logic              fe_n;
  logic              ov_n;
  logic              last_bit;
  logic              timeout;
  logic              complete;
  logic              load;

  // sclk and data see identical delay, so the bit pairs with its edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      data_sync <= '0;
      sclk_dly  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      data_sync <= {data_sync[0], spi_data};
      sclk_dly  <= sclk_sync[1];
    end
  end

  assign sample   = sclk_sync[1] & ~sclk_dly;
  assign bit_in   = data_sync[1];
  assign word     = {shift_reg[DATA_W-2:0], bit_in};
  assign last_bit = (bit_count == CNT_W'(DATA_W - 1));
  assign timeout  = (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));
  assign busy     = (state == SHIFT);

  always_comb begin
    state_n  = state;
    shift_n  = shift_reg;
    cnt_n    = bit_count;
    idle_n   = idle_cnt;
    complete = 1'b0;
    fe_n     = 1'b0;
    unique case (state)
      IDLE: begin
        idle_n = '0;
        cnt_n  = '0;
        if (sample) begin
          shift_n = word;
          cnt_n   = CNT_W'(1);
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (sample) begin
          shift_n = word;
          idle_n  = '0;
          if (last_bit) begin
            cnt_n    = '0;
            complete = 1'b1;
            state_n  = IDLE;
          end else begin
            cnt_n = bit_count + CNT_W'(1);
          end
        end else if (timeout) begin
          fe_n    = 1'b1;
          shift_n = '0;
          cnt_n   = '0;
          idle_n  = '0;
          state_n = IDLE;
        end else begin
          idle_n = idle_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // a finished frame may replace a word leaving in the same cycle
  always_comb begin
    data_n  = rx_data;
    valid_n = rx_valid;
    load    = 1'b0;
    ov_n    = 1'b0;
    if (rx_valid && rx_ready) begin
      valid_n = 1'b0;
    end
    if (complete) begin
      if (!rx_valid || rx_ready) begin
        load    = 1'b1;
        data_n  = word;
        valid_n = 1'b1;
      end else begin
        ov_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_count <= '0;
      idle_cnt  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_count <= cnt_n;
      idle_cnt  <= idle_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= fe_n;
      overrun   <= ov_n;
    end
  end

`ifdef SPI_RX_CHECKSUM_EN
  logic [7:0] chk_calc;
  logic       chk_n;

  assign chk_calc = word[39:32] ^ word[31:24]
                  ^ word[23:16] ^ word[15:8];

  always_comb begin
    chk_n = chk_err;
    if (!valid_n) begin
      chk_n = 1'b0;
    end else if (load) begin
      chk_n = (word[7:0] != chk_calc);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_err <= 1'b0;
    end else begin
      chk_err <= chk_n;
    end
  end
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed and randomized checks for spi_frame_receiver.
// Frames are modelled as whole words against a one-entry output buffer.
module tb_spi_frame_receiver;

  logic        clk;
  logic        reset;
  logic        spi_sclk;
  logic        spi_data;
  logic [39:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  bit_count;
  logic        frame_err;
  logic        overrun;
  logic        busy;
`ifdef SPI_RX_CHECKSUM_EN
  logic        chk_err;
`endif

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [39:0] got_q[$];
  logic        got_chk[$];

  spi_frame_receiver dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sclk  (spi_sclk),
    .spi_data  (spi_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .bit_count (bit_count),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef SPI_RX_CHECKSUM_EN
    .chk_err   (chk_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid && rx_ready) begin
      got_q.push_back(rx_data);
`ifdef SPI_RX_CHECKSUM_EN
      got_chk.push_back(chk_err);
`else
      got_chk.push_back(1'b0);
`endif
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic chk_of(input logic [39:0] w);
    return w[7:0] != (w[39:32] ^ w[31:24]
                    ^ w[23:16] ^ w[15:8]);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [39:0] w,
                      input int n, input int half);
    for (int i = 0; i < n; i++) begin
      spi_data = w[39-i];
      spi_sclk = 1'b0;
      cycles(half);
      spi_sclk = 1'b1;
      cycles(half);
    end
  endtask

  initial begin
    int base;
    int fe0;
    int ov0;
    int exp_ov;
    logic        held;
    logic [39:0] held_w;
    logic [39:0] w;
    logic [39:0] exp_q[$];

    reset = 1'b1;
    spi_sclk = 1'b0;
    spi_data = 1'b0;
    rx_ready = 1'b1;
    cycles(4);
    check("rst_valid", 64'(rx_valid), 64'd0);
    check("rst_data", 64'(rx_data), 64'd0);
    check("rst_count", 64'(bit_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    cycles(3);
    check("rel_fe", 64'(frame_err), 64'd0);
    check("rel_ov", 64'(overrun), 64'd0);

    base = got_q.size();
    valid_cycles = 0;
    send(40'hA55A0FF000, 40, 4);
    spi_sclk = 1'b0;
    cycles(8);
    check("t1_vcycles", 64'(valid_cycles), 64'd1);
    check("t1_count", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() > base) begin
      check("t1_data", 64'(got_q[base]), 64'hA55A0FF000);
`ifdef SPI_RX_CHECKSUM_EN
      check("t1_chk", 64'(got_chk[base]), 64'd0);
`endif
    end
    check("t1_fe", 64'(fe_cnt), 64'd0);
    check("t1_ov", 64'(ov_cnt), 64'd0);

    rx_ready = 1'b0;
    base = got_q.size();
    send(40'h123456789A, 40, 4);
    spi_sclk = 1'b0;
    cycles(8);
    check("t2_valid", 64'(rx_valid), 64'd1);
    check("t2_data", 64'(rx_data), 64'h123456789A);
    cycles(10);
    check("t2_hold", 64'(rx_data), 64'h123456789A);
    ov0 = ov_cnt;
    send(40'hFFFFFFFFFF, 40, 3);
    spi_sclk = 1'b0;
    cycles(8);
    check("t3_ov", 64'(ov_cnt - ov0), 64'd1);
    check("t3_data", 64'(rx_data), 64'h123456789A);
    check("t3_valid", 64'(rx_valid), 64'd1);
    cycles(10);
    rx_ready = 1'b1;
    cycles(1);
    check("t2_drop", 64'(rx_valid), 64'd0);
    check("t2_cnt", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() > base)
      check("t2_got", 64'(got_q[base]), 64'h123456789A);

    fe0 = fe_cnt;
    send(40'h5A5A5A5A5A, 17, 4);
    check("t4_bits", 64'(bit_count), 64'd17);
    check("t4_busy", 64'(busy), 64'd1);
    spi_sclk = 1'b0;
    for (int k = 0; k < 200 && fe_cnt == fe0; k++)
      cycles(1);
    cycles(6);
    check("t4_fe", 64'(fe_cnt - fe0), 64'd1);
    check("t4_bits0", 64'(bit_count), 64'd0);
    check("t4_idle", 64'(busy), 64'd0);
    base = got_q.size();
    send(40'h0000000001, 40, 4);
    spi_sclk = 1'b0;
    cycles(8);
    check("t4_cnt", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() > base)
      check("t4_data", 64'(got_q[base]), 64'h0000000001);

    fe0 = fe_cnt;
    ov0 = ov_cnt;
    base = got_q.size();
    send(40'h0F0F0F0F0F, 20, 4);
    reset = 1'b1;
    spi_sclk = 1'b0;
    cycles(3);
    check("t5_count", 64'(bit_count), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    cycles(3);
    send(40'hC3C3C3C3C3, 40, 4);
    spi_sclk = 1'b0;
    cycles(8);
    check("t5_cnt", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() > base)
      check("t5_data", 64'(got_q[base]), 64'hC3C3C3C3C3);
    check("t5_fe", 64'(fe_cnt - fe0), 64'd0);
    check("t5_ov", 64'(ov_cnt - ov0), 64'd0);

`ifdef SPI_RX_CHECKSUM_EN
    base = got_q.size();
    send(40'hA55A0FF001, 40, 4);
    spi_sclk = 1'b0;
    cycles(8);
    check("t6_cnt", 64'(got_q.size() - base), 64'd1);
    if (got_q.size() > base) begin
      check("t6_data", 64'(got_q[base]), 64'hA55A0FF001);
      check("t6_chk", 64'(got_chk[base]), 64'd1);
    end
`endif

    base = got_q.size();
    ov0 = ov_cnt;
    exp_ov = 0;
    held = 1'b0;
    held_w = '0;
    for (int f = 0; f < 10; f++) begin
      w = {8'($urandom), 32'($urandom)};
      rx_ready = 1'($urandom_range(0, 1));
      if (rx_ready) begin
        if (held) exp_q.push_back(held_w);
        held = 1'b0;
        exp_q.push_back(w);
      end else if (held) begin
        exp_ov++;
      end else begin
        held = 1'b1;
        held_w = w;
      end
      send(w, 40, $urandom_range(3, 6));
      spi_sclk = 1'b0;
      cycles(8);
    end
    rx_ready = 1'b1;
    if (held) exp_q.push_back(held_w);
    cycles(4);
    check("rnd_ov", 64'(ov_cnt - ov0), 64'(exp_ov));
    check("rnd_cnt", 64'(got_q.size() - base),
          64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        check("rnd_data", 64'(got_q[base+i]), 64'(exp_q[i]));
`ifdef SPI_RX_CHECKSUM_EN
        check("rnd_chk", 64'(got_chk[base+i]),
              64'(chk_of(exp_q[i])));
`endif
      end
    end
    check("end_valid", 64'(rx_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
